// File: rtl/uart_pkg.sv
// Shared types and config-field definitions for the UART packet assembler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  localparam logic [1:0] CFG_IGNORE  = 2'b10;
  localparam int unsigned CFG_LEN_LSB = 0;
  localparam int unsigned CFG_LEN_MSB = 1;
  localparam int unsigned CFG_IGN_LSB = 4;
  localparam int unsigned CFG_IGN_MSB = 5;

  // Packet length selected by a config byte, clipped to the packet capacity.
  function automatic int unsigned cfg_len(input logic [7:0] cfg, input int unsigned max_bytes);
    int unsigned len;
    len = int'(cfg[CFG_LEN_MSB:CFG_LEN_LSB]) + 1;
    return (len > max_bytes) ? max_bytes : len;
  endfunction

endpackage

// File: rtl/uart_timeout_timer.sv
// Saturating idle-cycle counter; expired stays high until cleared.
module uart_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/uart_packet_assembler.sv
// Assembles 1..MAX_BYTES received bytes into one packet word with a valid/ready output,
// inter-byte timeout, overrun flag and config register.
module uart_packet_assembler
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_BYTES   = 4,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter logic [DATA_W-1:0] CFG_RESET = 8'h0C
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  input  logic [DATA_W-1:0]              cfg_data,
  input  logic                           rx_valid,
  input  logic [DATA_W-1:0]              rx_data,
  input  logic                           pkt_ready,
  output logic                           pkt_valid,
  output logic [MAX_BYTES*DATA_W-1:0]    pkt_data,
  output logic [$clog2(MAX_BYTES+1)-1:0] pkt_len,
  output logic [DATA_W-1:0]              cfg_reg,
  output logic                           cfg_pulse,
  output logic                           err_timeout,
  output logic                           err_overrun
);

  localparam int unsigned PKT_W = MAX_BYTES * DATA_W;
  localparam int unsigned LEN_W = $clog2(MAX_BYTES + 1);

  state_t            state;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  len_lat;
  logic [LEN_W-1:0]  len_next;
  logic [DATA_W-1:0] cfg_eff;
  logic              cfg_ok;
  logic              hs;
  logic              take_first;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_expired;

  // A config byte arriving with the first byte of a packet already governs its length.
  always_comb begin
    cfg_ok     = cfg_valid && (cfg_data[CFG_IGN_MSB:CFG_IGN_LSB] != CFG_IGNORE);
    cfg_eff    = cfg_ok ? cfg_data : cfg_reg;
    len_next   = LEN_W'(cfg_len(8'(cfg_eff), MAX_BYTES));
    hs         = pkt_valid && pkt_ready;
    take_first = rx_valid && ((state == IDLE) || ((state == HOLD) && hs));
    tmr_en     = (state == COLLECT) && !rx_valid;
    tmr_clear  = (state != COLLECT) || rx_valid;
  end

  uart_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cfg_reg     <= CFG_RESET;
      count       <= '0;
      len_lat     <= '0;
      pkt_data    <= '0;
      pkt_len     <= '0;
      pkt_valid   <= 1'b0;
      cfg_pulse   <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      cfg_pulse   <= cfg_ok;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      if (cfg_ok) cfg_reg <= cfg_data;

      unique case (state)
        IDLE, HOLD: begin
          if ((state == HOLD) && hs) begin
            pkt_valid <= 1'b0;
            state     <= IDLE;
          end
          // Handshake and new byte in one cycle: the byte starts the next packet.
          if (take_first) begin
            pkt_data <= PKT_W'(rx_data);
            count    <= LEN_W'(1);
            len_lat  <= len_next;
            if (len_next == LEN_W'(1)) begin
              state     <= HOLD;
              pkt_valid <= 1'b1;
              pkt_len   <= len_next;
            end else begin
              state <= COLLECT;
            end
          end else if ((state == HOLD) && rx_valid) begin
            err_overrun <= 1'b1;
          end
        end

        COLLECT: begin
          if (rx_valid) begin
            pkt_data[int'(count)*DATA_W +: DATA_W] <= rx_data;
            count <= count + 1'b1;
            if ((count + 1'b1) == len_lat) begin
              state     <= HOLD;
              pkt_valid <= 1'b1;
              pkt_len   <= len_lat;
            end
          end else if (tmr_expired) begin
            err_timeout <= 1'b1;
            count       <= '0;
            pkt_data    <= '0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_assembler.sv
// Directed table-driven bench for uart_packet_assembler plus timeout and reset sequences.
module tb_uart_packet_assembler;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        pkt_ready = 1'b0;
  logic        pkt_valid;
  logic [31:0] pkt_data;
  logic [2:0]  pkt_len;
  logic [7:0]  cfg_reg;
  logic        cfg_pulse;
  logic        err_timeout;
  logic        err_overrun;

  int checks = 0;
  int failures = 0;

  uart_packet_assembler #(
    .DATA_W     (8),
    .MAX_BYTES  (4),
    .TIMEOUT_CYC(T),
    .CFG_RESET  (8'h0C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .pkt_ready  (pkt_ready),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_len    (pkt_len),
    .cfg_reg    (cfg_reg),
    .cfg_pulse  (cfg_pulse),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        cv;
    logic [7:0]  cd;
    logic        rdy;
    logic        pv;
    logic [31:0] pd;
    logic [2:0]  pl;
    logic [7:0]  cfg;
    logic        cp;
    logic        ov;
    logic        to;
  } vec_t;

  function automatic vec_t mk(input logic rxv, input logic [7:0] rxd, input logic cv,
                              input logic [7:0] cd, input logic rdy, input logic pv,
                              input logic [31:0] pd, input logic [2:0] pl, input logic [7:0] cfg,
                              input logic cp, input logic ov, input logic to);
    vec_t v;
    v.rxv = rxv; v.rxd = rxd; v.cv = cv; v.cd = cd; v.rdy = rdy;
    v.pv = pv; v.pd = pd; v.pl = pl; v.cfg = cfg; v.cp = cp; v.ov = ov; v.to = to;
    return v;
  endfunction

  // Packed view: {pv, pd, pl, cfg, cp, ov, to}
  function automatic logic [46:0] outs();
    return {pkt_valid, pkt_data, pkt_len, cfg_reg, cfg_pulse, err_overrun, err_timeout};
  endfunction

  task automatic check(input string name, input logic [46:0] act, input logic [46:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got pv=%b pd=%h len=%0d cfg=%h cp=%b ov=%b to=%b, expected pv=%b pd=%h len=%0d cfg=%h cp=%b ov=%b to=%b",
               name, act[46], act[45:14], act[13:11], act[10:3], act[2], act[1], act[0],
               exp[46], exp[45:14], exp[13:11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic rxv, input logic [7:0] rxd, input logic cv,
                      input logic [7:0] cd, input logic rdy);
    rx_valid = rxv; rx_data = rxd; cfg_valid = cv; cfg_data = cd; pkt_ready = rdy;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; cfg_valid = 1'b0;
  endtask

  vec_t tbl[26];

  initial begin
    int k;
    bit seen_to;
    bit seen_pv;

    //           rxv rxd    cv cd     rdy  pv pd            pl cfg    cp ov to
    tbl[0]  = mk(0, 8'h00, 0, 8'h00, 0,   0, 32'h00000000, 0, 8'h0C, 0, 0, 0);
    tbl[1]  = mk(1, 8'hA5, 0, 8'h00, 0,   1, 32'h000000A5, 1, 8'h0C, 0, 0, 0);
    tbl[2]  = mk(0, 8'h00, 0, 8'h00, 1,   0, 32'h000000A5, 1, 8'h0C, 0, 0, 0);
    tbl[3]  = mk(0, 8'h00, 1, 8'h03, 0,   0, 32'h000000A5, 1, 8'h03, 1, 0, 0);
    tbl[4]  = mk(1, 8'h11, 0, 8'h00, 1,   0, 32'h00000011, 1, 8'h03, 0, 0, 0);
    tbl[5]  = mk(1, 8'h22, 0, 8'h00, 1,   0, 32'h00002211, 1, 8'h03, 0, 0, 0);
    tbl[6]  = mk(1, 8'h33, 0, 8'h00, 1,   0, 32'h00332211, 1, 8'h03, 0, 0, 0);
    tbl[7]  = mk(1, 8'h44, 0, 8'h00, 1,   1, 32'h44332211, 4, 8'h03, 0, 0, 0);
    tbl[8]  = mk(0, 8'h00, 0, 8'h00, 1,   0, 32'h44332211, 4, 8'h03, 0, 0, 0);
    tbl[9]  = mk(0, 8'h00, 1, 8'h22, 0,   0, 32'h44332211, 4, 8'h03, 0, 0, 0);
    tbl[10] = mk(1, 8'h01, 0, 8'h00, 1,   0, 32'h00000001, 4, 8'h03, 0, 0, 0);
    tbl[11] = mk(1, 8'h02, 1, 8'h01, 1,   0, 32'h00000201, 4, 8'h01, 1, 0, 0);
    tbl[12] = mk(1, 8'h03, 0, 8'h00, 1,   0, 32'h00030201, 4, 8'h01, 0, 0, 0);
    tbl[13] = mk(1, 8'h04, 0, 8'h00, 1,   1, 32'h04030201, 4, 8'h01, 0, 0, 0);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 1,   0, 32'h04030201, 4, 8'h01, 0, 0, 0);
    tbl[15] = mk(1, 8'hAA, 0, 8'h00, 0,   0, 32'h000000AA, 4, 8'h01, 0, 0, 0);
    tbl[16] = mk(1, 8'hBB, 0, 8'h00, 0,   1, 32'h0000BBAA, 2, 8'h01, 0, 0, 0);
    tbl[17] = mk(1, 8'h77, 0, 8'h00, 0,   1, 32'h0000BBAA, 2, 8'h01, 0, 1, 0);
    tbl[18] = mk(0, 8'h00, 0, 8'h00, 0,   1, 32'h0000BBAA, 2, 8'h01, 0, 0, 0);
    tbl[19] = mk(1, 8'h55, 0, 8'h00, 1,   0, 32'h00000055, 2, 8'h01, 0, 0, 0);
    tbl[20] = mk(1, 8'h66, 0, 8'h00, 0,   1, 32'h00006655, 2, 8'h01, 0, 0, 0);
    tbl[21] = mk(0, 8'h00, 0, 8'h00, 1,   0, 32'h00006655, 2, 8'h01, 0, 0, 0);
    tbl[22] = mk(1, 8'h10, 1, 8'h02, 1,   0, 32'h00000010, 2, 8'h02, 1, 0, 0);
    tbl[23] = mk(1, 8'h20, 0, 8'h00, 1,   0, 32'h00002010, 2, 8'h02, 0, 0, 0);
    tbl[24] = mk(1, 8'h30, 0, 8'h00, 0,   1, 32'h00302010, 3, 8'h02, 0, 0, 0);
    tbl[25] = mk(0, 8'h00, 0, 8'h00, 1,   0, 32'h00302010, 3, 8'h02, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), {1'b0, 32'h0, 3'd0, 8'h0C, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rxv, tbl[i].rxd, tbl[i].cv, tbl[i].cd, tbl[i].rdy);
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].pv, tbl[i].pd, tbl[i].pl, tbl[i].cfg, tbl[i].cp, tbl[i].ov, tbl[i].to});
    end

    // Timeout: length 3 configured, two bytes then silence.
    step(1, 8'hC1, 0, 8'h00, 1);
    step(1, 8'hC2, 0, 8'h00, 1);
    seen_to = 1'b0;
    seen_pv = 1'b0;
    k = 0;
    while (!seen_to && k < 3 * T) begin
      step(0, 8'h00, 0, 8'h00, 1);
      k++;
      if (pkt_valid) seen_pv = 1'b1;
      if (err_timeout) seen_to = 1'b1;
    end
    check_bit("timeout_seen", seen_to, 1'b1);
    check_bit("timeout_window", (k >= T - 1) && (k <= T + 1), 1'b1);
    check_bit("timeout_no_pkt", seen_pv, 1'b0);
    step(0, 8'h00, 0, 8'h00, 1);
    check("timeout_after", outs(), {1'b0, 32'h0, 3'd3, 8'h02, 1'b0, 1'b0, 1'b0});
    step(1, 8'hD1, 0, 8'h00, 0);
    step(1, 8'hD2, 0, 8'h00, 0);
    step(1, 8'hD3, 0, 8'h00, 0);
    check("post_timeout_pkt", outs(), {1'b1, 32'h00D3D2D1, 3'd3, 8'h02, 1'b0, 1'b0, 1'b0});
    step(0, 8'h00, 0, 8'h00, 1);
    check_bit("post_timeout_hs", pkt_valid, 1'b0);

    // Reset mid-packet.
    step(1, 8'hE1, 0, 8'h00, 0);
    step(1, 8'hE2, 0, 8'h00, 0);
    rst = 1'b1;
    step(0, 8'h00, 0, 8'h00, 0);
    rst = 1'b0;
    check("mid_reset", outs(), {1'b0, 32'h0, 3'd0, 8'h0C, 1'b0, 1'b0, 1'b0});
    step(0, 8'h00, 0, 8'h00, 0);
    check("mid_reset_quiet", outs(), {1'b0, 32'h0, 3'd0, 8'h0C, 1'b0, 1'b0, 1'b0});
    step(1, 8'hE7, 0, 8'h00, 0);
    check("fresh_pkt", outs(), {1'b1, 32'h000000E7, 3'd1, 8'h0C, 1'b0, 1'b0, 1'b0});
    step(0, 8'h00, 0, 8'h00, 1);
    check_bit("fresh_hs", pkt_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
